uart_tx_io: RTL and testbench
=============================

# uart_tx_io

Memory-mapped UART transmitter on the pipeline's data-memory port, the consumer of the Memory stage's `Address`/`WriteData`/`MemWrite` outputs for the I/O region (`Address[22]`=1). It buffers bytes written by software in a small FIFO and serialises them as 8N1 frames on `txd` with a programmable baud divider. Status reads return combinationally on `io_rdata`, so the Memory stage samples them in the same cycle that it presents the address.

## Interface
- `FIFO_DEPTH`, 8: TX FIFO entries; must be a power of two, ≥2.
- `BAUD_DIV_RESET`, 16: reset value of BAUDDIV, in clocks per bit.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- Address  in  32  byte address from Memory stage; selected when bit 22=1; register offset = `Address[3:2]`.
- WriteData  in  32  store data; only `[7:0]` or `[15:0]` used per register.
- MemWrite  in  1  store strobe, one cycle per store.
- io_rdata  out  32  combinational read data for the selected register; 0 when not selected.
- txd  out  1  serial output, registered, idle high.

## Operation
- Register map, by offset:
  - 0 TXDATA (W): pushes `WriteData[7:0]`. Reads 0.
  - 1 STATUS (R): bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), `[8+:4]` FIFO count. Any write clears overflow.
  - 2 BAUDDIV (RW): 16 bits. A value of 0 behaves as 1.
  - 3: reserved. Reads 0; writes are ignored.
- Push is accepted when `MemWrite & Address[22] & offset==0` and count<FIFO_DEPTH, with count evaluated before any same-cycle pop.
- A push to a full FIFO is dropped and sets overflow, even if a pop occurs in the same cycle.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits wide.
- FSM states:
  - IDLE → START when the FIFO is non-empty; pop into the shift register.
  - START (txd=0) → DATA.
  - DATA sends 8 bits, LSB first → PARITY if enabled, else STOP.
  - PARITY → STOP.
  - STOP (txd=1) → START with a pop if the FIFO is non-empty, else IDLE.
- Each non-IDLE state lasts exactly one bit period of max(BAUDDIV,1) clocks, counted by a down-counter reloaded at each bit boundary.
- A BAUDDIV write mid-frame takes effect at the next bit boundary; the current bit completes at the old period.
- Reset, including mid-frame:
  - FIFO emptied, pointers 0.
  - overflow=0, BAUDDIV=BAUD_DIV_RESET.
  - FSM=IDLE, txd=1 from the edge that samples reset.
  - The partial frame is abandoned.

## Timing
- Write latency: a TXDATA push sampled at edge E0 with the FSM IDLE gives txd=0 from edge E1.
- Frame length is 10·N clocks (11·N with parity), N=max(BAUDDIV,1).
- Back-to-back frames have no idle gap: the next start bit begins the clock after the previous stop bit ends.
- io_rdata is purely combinational from the registered state; STATUS reflects the state before the current edge's updates.
- Reset values: txd=1; io_rdata=0 when unselected; with `Address[22]`=1 and offset 1 it reads 0x004 (empty, count 0).

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds the PARITY state, which sends even parity (XOR of the 8 data bits) between the data and stop bits.
  - Frames are 11·N clocks.
  - STATUS bit4 reads 1, identifying the build.
- `UART_TX_PARITY_EN` undefined:
  - The PARITY state does not exist.
  - Frames are 10·N clocks; STATUS bit4 reads 0.

## Test plan
- Reset, then read offset 1 → io_rdata=0x004; txd=1; a read with `Address[22]`=0 → 0.
- BAUDDIV=4, write 0x55 at edge E0:
  - txd=0 during E1..E5.
  - Then bits 1,0,1,0,1,0,1,0, each held 4 clocks.
  - Then txd=1 stop bit; busy=0 at E1+40 (E1+44 with parity).
- Write 9 bytes 0x01..0x09 at 1/clock while BAUDDIV=100:
  - The first is popped immediately; all 9 are accepted, with count peaking at 8.
  - A 10th write in the same burst → overflow=1; frames carry 0x01..0x09 back-to-back with no idle gap.
  - A write to STATUS clears overflow.
- FIFO full with a pop in the same cycle as a push → push dropped, overflow=1, count=7.
- BAUDDIV=0 → each bit lasts 1 clock and a frame lasts 10 clocks; a BAUDDIV change from 4 to 8 mid-bit → the current bit stays 4 clocks and the next bit is 8.
- Assert reset mid-DATA → txd=1 next edge, STATUS=0x004, BAUDDIV reads BAUD_DIV_RESET.

Source files
------------

// File: rtl/uart_tx_io.sv
// ============================================================================
// uart_tx_io
// ----------------------------------------------------------------------------
// Memory-mapped 8N1 UART transmitter for the I/O region of the data-memory
// port (Address[22] = 1). Software stores bytes into a small TX FIFO; an FSM
// pops them and shifts them out on txd, LSB first, at a programmable number
// of clocks per bit. Register reads are combinational so the Memory stage
// can sample io_rdata in the same cycle it presents the address.
//
// Register map (offset = Address[3:2]):
//   0 TXDATA  (W)  push WriteData[7:0]; reads 0
//   1 STATUS  (R)  bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky),
//                  bit4 parity build, [11:8] FIFO count; any write clears
//                  overflow
//   2 BAUDDIV (RW) clocks per bit, 16 bits; 0 behaves as 1
//   3 reserved     reads 0, writes ignored
//
// Parameters:
//   FIFO_DEPTH     TX FIFO entries, power of two, >= 2
//   BAUD_DIV_RESET reset value of BAUDDIV
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high
//   Address    byte address from the Memory stage
//   WriteData  store data
//   MemWrite   store strobe, one cycle per store
//   io_rdata   combinational read data, 0 when not selected
//   txd        registered serial output, idle high
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even-parity bit is sent between the
//                      data and stop bits (11-bit frames) and STATUS bit4
//                      reads 1. Undefined by default (10-bit frames).
// ============================================================================
module uart_tx_io #(
  parameter int FIFO_DEPTH     = 8,
  parameter int BAUD_DIV_RESET = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  output logic [31:0] io_rdata,
  output logic        txd
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_BUILD = 1'b1;
`else
  localparam logic PARITY_BUILD = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [15:0]   baud_div;

  // Transmit engine
  state_t        state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_idx;
  logic [15:0]   baud_cnt;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  // Decode and handshake terms
  logic [1:0]    offset;
  logic          sel;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_baud;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic [15:0]   reload;
  logic [7:0]    fifo_head;
  logic [31:0]   count_ext;
  logic          unused_bits;

  assign offset     = Address[3:2];
  assign sel        = Address[22];
  assign wr_txdata  = MemWrite & sel & (offset == OFF_TXDATA);
  assign wr_status  = MemWrite & sel & (offset == OFF_STATUS);
  assign wr_baud    = MemWrite & sel & (offset == OFF_BAUDDIV);

  // Full/empty are taken from the count before this edge, so a push into a
  // full FIFO is refused even when the FSM pops in the same cycle.
  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign push       = wr_txdata & ~fifo_full;

  // The down-counter reaches zero on the last clock of a bit period.
  assign bit_end    = (baud_cnt == 16'd0);

  // A new byte is taken either from IDLE or at the end of a stop bit, which
  // is what makes back-to-back frames gapless.
  assign pop        = ~fifo_empty & ((state == IDLE) | ((state == STOP) & bit_end));

  // Counter reload for a full bit period; a divider of 0 acts like 1.
  assign reload     = (baud_div == 16'd0) ? 16'd0 : (baud_div - 16'd1);

  assign fifo_head  = fifo_mem[rd_ptr];
  assign count_ext  = 32'(count);

  // Address and data bits that this block never looks at.
  assign unused_bits = ^{Address[31:23], Address[21:4], Address[1:0], WriteData[31:16]};

  // FIFO storage; entries need no reset because the pointers and count
  // define which ones are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= WriteData[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. Pointers are
  // exactly log2(depth) bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_status) begin
        overflow <= 1'b0;
      end else if (wr_txdata && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // Baud divider register. A new value is only picked up when the bit
  // counter reloads, so the bit in flight keeps its old length.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_div <= 16'(BAUD_DIV_RESET);
    end else if (wr_baud) begin
      baud_div <= WriteData[15:0];
    end
  end

  // Transmit FSM. txd is registered and changes together with the state, so
  // each state owns exactly one bit period on the line. The data byte is
  // shifted right so shift_reg[0] is always the next bit to send.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      txd       <= 1'b1;
      shift_reg <= 8'd0;
      bit_idx   <= 3'd0;
      baud_cnt  <= 16'd0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!fifo_empty) begin
            state     <= START;
            txd       <= 1'b0;
            shift_reg <= fifo_head;
            baud_cnt  <= reload;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^fifo_head;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            state     <= DATA;
            txd       <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= 3'd0;
            baud_cnt  <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= reload;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_q;
`else
              state <= STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd       <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_idx   <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            txd      <= 1'b1;
            baud_cnt <= reload;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_cnt <= reload;
            if (!fifo_empty) begin
              state     <= START;
              txd       <= 1'b0;
              shift_reg <= fifo_head;
`ifdef UART_TX_PARITY_EN
              parity_q  <= ^fifo_head;
`endif
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Register read mux, purely from registered state so it reflects the
  // values before the current edge.
  always_comb begin
    io_rdata = 32'd0;
    if (sel) begin
      case (offset)
        OFF_STATUS: begin
          io_rdata[0]    = (state != IDLE);
          io_rdata[1]    = fifo_full;
          io_rdata[2]    = fifo_empty;
          io_rdata[3]    = overflow;
          io_rdata[4]    = PARITY_BUILD;
          io_rdata[11:8] = count_ext[3:0];
        end
        OFF_BAUDDIV: begin
          io_rdata[15:0] = baud_div;
        end
        default: begin
          io_rdata = 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// ============================================================================
// tb_uart_tx_io
// ----------------------------------------------------------------------------
// Self-checking bench for uart_tx_io. Each byte the bench expects on txd is
// queued together with its expected per-bit lengths; a monitor watches txd
// at the falling clock edge, pops the matching entry when a start bit
// appears and checks every bit's value and length, plus the absence of an
// idle gap for frames that must follow their predecessor directly. Register
// reads are checked directly against hand-computed values.
// ============================================================================
module tb_uart_tx_io;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic [31:0] io_rdata;
  logic        txd;

`ifdef UART_TX_PARITY_EN
  localparam int          NB = 11;
  localparam logic [31:0] PB = 32'h10;
`else
  localparam int          NB = 10;
  localparam logic [31:0] PB = 32'h00;
`endif

  localparam logic [31:0] ST_IDLE = 32'h004 | PB;

  typedef struct packed {
    logic [7:0]        data;
    logic [10:0][15:0] per;
    logic              b2b;
  } frame_t;

  frame_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  bit     mon_active = 1'b0;

  always #5 clk = ~clk;

  uart_tx_io #(
    .FIFO_DEPTH(8),
    .BAUD_DIV_RESET(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .io_rdata(io_rdata),
    .txd(txd)
  );

  function automatic frame_t mk_frame(input logic [7:0] d, input int n, input logic b2b);
    frame_t f;
    f.data = d;
    f.b2b  = b2b;
    for (int i = 0; i < 11; i++) f.per[i] = 16'(n);
    return f;
  endfunction

  function automatic logic exp_bit(input frame_t f, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return f.data[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^f.data;
`endif
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One store to register offset 'off', sampled at the next rising edge.
  task automatic applyStimulus(input int off, input logic [31:0] data);
    Address   = 32'h0040_0000 | (32'(off) << 2);
    WriteData = data;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic read_reg(input int off, output logic [31:0] v);
    Address  = 32'h0040_0000 | (32'(off) << 2);
    MemWrite = 1'b0;
    #1;
    v = io_rdata;
  endtask

  task automatic check_reg(input string name, input int off, input logic [31:0] expected);
    logic [31:0] v;
    read_reg(off, v);
    checkOutput(name, v, expected);
  endtask

  task automatic wait_idle(input int limit);
    logic [31:0] s;
    int c = 0;
    forever begin
      read_reg(1, s);
      if (s == ST_IDLE && !mon_active && exp_q.size() == 0) break;
      if (c >= limit) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL idle_timeout: status 0x%0h, %0d frames outstanding", s, exp_q.size());
        break;
      end
      tick();
      c++;
    end
  endtask

  // txd monitor / scoreboard consumer
  initial begin
    frame_t cur;
    int     idle_cnt   = 0;
    int     bit_idx    = 0;
    int     clk_in_bit = 0;
    logic   ok         = 1'b1;
    bit     skip_low   = 1'b0;
    cur = '0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        mon_active = 1'b0;
        idle_cnt   = 0;
        skip_low   = 1'b0;
      end else begin
        if (!mon_active) begin
          if (txd === 1'b0) begin
            if (skip_low) begin
              idle_cnt = 0;
            end else if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              skip_low = 1'b1;
              $display("[TB] FAIL unexpected_frame: start bit seen with no frame expected");
            end else begin
              cur = exp_q.pop_front();
              if (cur.b2b) checkOutput($sformatf("frame_%02h_gap", cur.data), idle_cnt, 0);
              mon_active = 1'b1;
              bit_idx    = 0;
              clk_in_bit = 0;
              ok         = 1'b1;
            end
          end else begin
            skip_low = 1'b0;
            idle_cnt++;
          end
        end
        if (mon_active) begin
          if (txd !== exp_bit(cur, bit_idx)) ok = 1'b0;
          clk_in_bit++;
          if (clk_in_bit == int'(cur.per[bit_idx])) begin
            checkOutput($sformatf("frame_%02h_bit%0d", cur.data, bit_idx), ok, 1);
            bit_idx++;
            clk_in_bit = 0;
            ok = 1'b1;
            if (bit_idx == NB) begin
              mon_active = 1'b0;
              idle_cnt   = 0;
            end
          end
        end
      end
    end
  end

  // Watchdog
  initial begin
    #900_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus
  initial begin
    frame_t f;
    reset     = 1'b1;
    Address   = 32'd0;
    WriteData = 32'd0;
    MemWrite  = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state and register map
    check_reg("reset_status", 1, ST_IDLE);
    checkOutput("reset_txd", txd, 1);
    Address = 32'h0000_0004;
    #1;
    checkOutput("unselected_read", io_rdata, 0);
    check_reg("reset_bauddiv", 2, 16);
    tick();
    check_reg("reserved_read", 3, 0);
    check_reg("txdata_read", 0, 0);

    // Stores outside the I/O region or to the reserved slot do nothing
    Address   = 32'h0000_0000;
    WriteData = 32'h77;
    MemWrite  = 1'b1;
    tick();
    MemWrite  = 1'b0;
    applyStimulus(3, 32'h1234);
    check_reg("ignored_writes_status", 1, ST_IDLE);
    check_reg("ignored_writes_baud", 2, 16);
    tick();

    // 0x55 at 4 clocks per bit: latency, bit timing, busy window
    applyStimulus(2, 4);
    exp_q.push_back(mk_frame(8'h55, 4, 1'b0));
    applyStimulus(0, 32'h55);
    check_reg("push_idle_status", 1, 32'h100 | PB);
    tick();
    checkOutput("start_latency_txd", txd, 0);
    check_reg("sending_status", 1, 32'h005 | PB);
    repeat (4 * NB - 1) tick();
    check_reg("last_clock_busy", 1, 32'h005 | PB);
    tick();
    check_reg("frame_done_idle", 1, ST_IDLE);
    wait_idle(50);

    // BAUDDIV = 0 behaves as one clock per bit
    applyStimulus(2, 0);
    check_reg("bauddiv_zero_read", 2, 0);
    exp_q.push_back(mk_frame(8'hA3, 1, 1'b0));
    applyStimulus(0, 32'hA3);
    tick();
    checkOutput("div0_start_txd", txd, 0);
    repeat (NB - 1) tick();
    check_reg("div0_last_clock_busy", 1, 32'h005 | PB);
    tick();
    check_reg("div0_frame_done", 1, ST_IDLE);
    wait_idle(50);

    // Divider change 4 -> 8 during the start bit
    applyStimulus(2, 4);
    f = mk_frame(8'h3C, 8, 1'b0);
    f.per[0] = 16'd4;
    exp_q.push_back(f);
    applyStimulus(0, 32'h3C);
    tick();
    tick();
    applyStimulus(2, 8);
    wait_idle(200);

    // Burst of 9 + 1 bytes at 100 clocks per bit
    applyStimulus(2, 100);
    exp_q.push_back(mk_frame(8'h01, 100, 1'b0));
    for (int i = 2; i <= 9; i++) exp_q.push_back(mk_frame(8'(i), 100, 1'b1));
    for (int i = 1; i <= 9; i++) applyStimulus(0, 32'(i));
    check_reg("burst_full_status", 1, 32'h803 | PB);
    applyStimulus(0, 32'h0A);
    check_reg("burst_overflow_status", 1, 32'h80B | PB);
    applyStimulus(1, 0);
    check_reg("overflow_cleared_status", 1, 32'h803 | PB);
    wait_idle(12000);

    // Push into a full FIFO on the same edge as a pop
    applyStimulus(2, 2);
    exp_q.push_back(mk_frame(8'hC1, 2, 1'b0));
    for (int i = 2; i <= 9; i++) exp_q.push_back(mk_frame(8'hC0 + 8'(i), 2, 1'b1));
    applyStimulus(0, 32'hC1);
    for (int i = 2; i <= 9; i++) applyStimulus(0, 32'hC0 + 32'(i));
    repeat (2 * NB - 8) tick();
    check_reg("full_before_pop", 1, 32'h803 | PB);
    applyStimulus(0, 32'hEE);
    check_reg("push_pop_full_status", 1, 32'h709 | PB);
    applyStimulus(1, 0);
    check_reg("status_write_clears", 1, 32'h701 | PB);
    wait_idle(400);

    // Reset in the middle of the data bits
    applyStimulus(2, 8);
    exp_q.push_back(mk_frame(8'h5A, 8, 1'b0));
    applyStimulus(0, 32'h5A);
    repeat (11) tick();
    reset = 1'b1;
    tick();
    checkOutput("midframe_reset_txd", txd, 1);
    check_reg("midframe_reset_status", 1, ST_IDLE);
    check_reg("midframe_reset_baud", 2, 16);
    exp_q.delete();
    reset = 1'b0;
    repeat (100) tick();
    check_reg("after_reset_idle", 1, ST_IDLE);
    checkOutput("after_reset_txd", txd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
